// File: rtl/sca_pingpong_pkg.sv
// Shared constants for the ping-pong buffer: bank encodings and occupancy width.
package sca_pingpong_pkg;
  localparam logic BANK_A  = 1'b0;
  localparam logic BANK_B  = 1'b1;
  localparam int   COUNT_W = 2;
endpackage

// File: rtl/sca_reg.sv
// Load-enabled data register with synchronous reset to zero; one cycle load latency.
module sca_reg #(
  parameter int SIZE = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            LD,
  input  logic [SIZE-1:0] D,
  output logic [SIZE-1:0] Q
);
  logic [SIZE-1:0] q_q;
  logic [SIZE-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (LD) q_d = D;
  end

  always_ff @(posedge CLK) begin
    if (RST) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;
endmodule

// File: rtl/sca_pingpong.sv
// Two-bank ping-pong buffer feeding a 2:1 mux; 1-cycle write-to-read latency.
// Valid/ready on both sides; all outputs come from registered state only.
module sca_pingpong
  import sca_pingpong_pkg::*;
#(
  parameter int SIZE = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [SIZE-1:0]    DIN,
  input  logic               WR_VALID,
  output logic               WR_READY,
  output logic [SIZE-1:0]    BUF_A,
  output logic [SIZE-1:0]    BUF_B,
  output logic               RD_SEL,
  output logic               RD_VALID,
  input  logic               RD_READY,
  output logic [COUNT_W-1:0] COUNT
);
  logic wp_q, wp_d;
  logic rp_q, rp_d;
  logic full_a_q, full_a_d;
  logic full_b_q, full_b_d;
  logic wr_acc, rd_acc;
  logic ld_a, ld_b;

  assign WR_READY = (wp_q == BANK_A) ? !full_a_q : !full_b_q;
  assign RD_VALID = (rp_q == BANK_A) ? full_a_q : full_b_q;
  assign RD_SEL   = rp_q;
  assign COUNT    = COUNT_W'(full_a_q) + COUNT_W'(full_b_q);

  assign wr_acc = WR_VALID && WR_READY;
  assign rd_acc = RD_VALID && RD_READY;
  assign ld_a   = wr_acc && (wp_q == BANK_A);
  assign ld_b   = wr_acc && (wp_q == BANK_B);

  // A write and a read in the same cycle always hit different banks, so set/clear never collide.
  always_comb begin
    wp_d     = wp_q ^ wr_acc;
    rp_d     = rp_q ^ rd_acc;
    full_a_d = full_a_q;
    full_b_d = full_b_q;
    if (ld_a) full_a_d = 1'b1;
    if (ld_b) full_b_d = 1'b1;
    if (rd_acc && (rp_q == BANK_A)) full_a_d = 1'b0;
    if (rd_acc && (rp_q == BANK_B)) full_b_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wp_q     <= BANK_A;
      rp_q     <= BANK_A;
      full_a_q <= 1'b0;
      full_b_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      full_a_q <= full_a_d;
      full_b_q <= full_b_d;
    end
  end

  sca_reg #(.SIZE(SIZE)) u_bank_a (
    .CLK (CLK),
    .RST (RST),
    .LD  (ld_a),
    .D   (DIN),
    .Q   (BUF_A)
  );

  sca_reg #(.SIZE(SIZE)) u_bank_b (
    .CLK (CLK),
    .RST (RST),
    .LD  (ld_b),
    .D   (DIN),
    .Q   (BUF_B)
  );
endmodule

// File: tb/tb_sca_pingpong.sv
// Randomized and directed bench for sca_pingpong, checked against a 2-deep FIFO model.
module tb_sca_pingpong;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       wr_valid = 1'b0;
  logic       rd_ready = 1'b0;
  logic       wr_ready, rd_sel, rd_valid;
  logic [7:0] buf_a, buf_b;
  logic [1:0] count;
  logic [7:0] mux_out;
  logic [20:0] obs;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  int n_wr = 0;
  int n_rd = 0;
  logic [7:0] m_a = '0;
  logic [7:0] m_b = '0;

  always #5 clk = ~clk;

  sca_pingpong #(.SIZE(8)) dut (
    .CLK      (clk),
    .RST      (rst),
    .DIN      (din),
    .WR_VALID (wr_valid),
    .WR_READY (wr_ready),
    .BUF_A    (buf_a),
    .BUF_B    (buf_b),
    .RD_SEL   (rd_sel),
    .RD_VALID (rd_valid),
    .RD_READY (rd_ready),
    .COUNT    (count)
  );

  assign mux_out = rd_sel ? buf_b : buf_a;
  assign obs = {wr_ready, rd_valid, count, rd_sel, buf_a, buf_b};

  function automatic logic [20:0] exp_vec();
    logic [1:0] c;
    logic       sel;
    c   = 2'(q.size());
    sel = (n_rd % 2) == 1;
    return {q.size() < 2, q.size() > 0, c, sel, m_a, m_b};
  endfunction

  // Drive one cycle of stimulus and advance the FIFO model across the edge.
  task automatic step(input logic r, input logic wv, input logic [7:0] d, input logic rr);
    bit w_ok, r_ok;
    rst = r; wr_valid = wv; din = d; rd_ready = rr;
    w_ok = wv && (q.size() < 2);
    r_ok = rr && (q.size() > 0);
    @(posedge clk);
    if (r) begin
      q.delete(); n_wr = 0; n_rd = 0; m_a = '0; m_b = '0;
    end else begin
      if (w_ok) begin
        if (n_wr % 2 == 0) m_a = d; else m_b = d;
        q.push_back(d);
        n_wr++;
      end
      if (r_ok) begin
        void'(q.pop_front());
        n_rd++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    checks++;
    if (obs !== 21'h100000) begin
      failures++;
      $display("FAIL reset_state obs=%h expected=%h", obs, 21'h100000);
    end
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL reset_model obs=%h expected=%h", obs, exp_vec());
    end
    step(0, 0, 8'h00, 0);
  endtask

  task automatic test_fill();
    step(0, 1, 8'hA5, 0);
    step(0, 1, 8'h3C, 0);
    checks++;
    if (buf_a !== 8'hA5 || buf_b !== 8'h3C) begin
      failures++;
      $display("FAIL fill_banks buf_a=%h buf_b=%h expected A5 3C", buf_a, buf_b);
    end
    checks++;
    if (count !== 2'd2 || wr_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full count=%0d wr_ready=%b expected 2 0", count, wr_ready);
    end
    step(0, 1, 8'hFF, 0);
    checks++;
    if (buf_a !== 8'hA5 || count !== 2'd2) begin
      failures++;
      $display("FAIL fill_held buf_a=%h count=%0d expected A5 2", buf_a, count);
    end
  endtask

  task automatic test_read_pending();
    // Read frees bank A while FF is still offered; it must not be taken this cycle.
    step(0, 1, 8'hFF, 1);
    checks++;
    if (rd_sel !== 1'b1 || count !== 2'd1 || wr_ready !== 1'b1 || buf_a !== 8'hA5) begin
      failures++;
      $display("FAIL read_from_full sel=%b count=%0d wr_ready=%b buf_a=%h expected 1 1 1 A5",
               rd_sel, count, wr_ready, buf_a);
    end
    step(0, 1, 8'hFF, 0);
    checks++;
    if (buf_a !== 8'hFF || count !== 2'd2) begin
      failures++;
      $display("FAIL pending_write buf_a=%h count=%0d expected FF 2", buf_a, count);
    end
    checks++;
    if (mux_out !== 8'h3C) begin
      failures++;
      $display("FAIL drain_first mux=%h expected 3C", mux_out);
    end
    step(0, 0, 8'h00, 1);
    checks++;
    if (mux_out !== 8'hFF || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL drain_second mux=%h rd_valid=%b expected FF 1", mux_out, rd_valid);
    end
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 1);
    checks++;
    if (obs !== exp_vec() || count !== 2'd0) begin
      failures++;
      $display("FAIL empty_ignore_read obs=%h expected=%h", obs, exp_vec());
    end
  endtask

  task automatic test_stream();
    logic prev_sel;
    step(0, 1, 8'h01, 0);
    for (int i = 2; i <= 16; i++) begin
      prev_sel = rd_sel;
      checks++;
      if (mux_out !== 8'(i - 1) || rd_valid !== 1'b1 || count !== 2'd1) begin
        failures++;
        $display("FAIL stream_word%0d mux=%h rd_valid=%b count=%0d expected %h 1 1",
                 i - 1, mux_out, rd_valid, count, 8'(i - 1));
      end
      step(0, 1, 8'(i), 1);
      checks++;
      if (rd_sel === prev_sel || count !== 2'd1) begin
        failures++;
        $display("FAIL stream_toggle%0d sel=%b prev=%b count=%0d expected toggle 1",
                 i, rd_sel, prev_sel, count);
      end
    end
    checks++;
    if (mux_out !== 8'h10) begin
      failures++;
      $display("FAIL stream_last mux=%h expected 10", mux_out);
    end
    step(0, 0, 8'h00, 1);
    checks++;
    if (obs !== exp_vec()) begin
      failures++;
      $display("FAIL stream_end obs=%h expected=%h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 8'h11, 0);
    step(0, 1, 8'h22, 0);
    step(1, 1, 8'h77, 0);
    checks++;
    if (obs !== 21'h100000) begin
      failures++;
      $display("FAIL reset_mid obs=%h expected=%h", obs, 21'h100000);
    end
    step(0, 0, 8'h00, 1);
    checks++;
    if (count !== 2'd0 || buf_a !== 8'h00 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_lost count=%0d buf_a=%h rd_valid=%b expected 0 00 0",
               count, buf_a, rd_valid);
    end
  endtask

  task automatic test_random();
    logic r, wv, rr;
    logic [7:0] d;
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 49) == 0);
      wv = ($urandom_range(0, 2) != 0);
      rr = ($urandom_range(0, 2) != 0);
      d  = 8'($urandom);
      step(r, wv, d, rr);
      checks++;
      if (obs !== exp_vec()) begin
        failures++;
        $display("FAIL random_cycle%0d obs=%h expected=%h", i, obs, exp_vec());
      end
      if (q.size() > 0) begin
        checks++;
        if (mux_out !== q[0]) begin
          failures++;
          $display("FAIL random_order%0d mux=%h expected=%h", i, mux_out, q[0]);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_read_pending();
    test_stream();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
